// File: rtl/ula_multiciclo_if.sv
// Handshake and operand/result bundle between the control unit and the multicycle ALU.
interface ula_multiciclo_if #(
   parameter int LARGURA = 32
);
   logic               inicio;
   logic [4:0]         ulaOP;
   logic [LARGURA-1:0] RS;
   logic [LARGURA-1:0] RT;
   logic [LARGURA-1:0] saidaULA;
   logic [LARGURA-1:0] saidaHI;
   logic [LARGURA-1:0] saidaLO;
   logic               ocupado;
   logic               pronto;
   logic               divZero;
   logic               opInvalido;

   modport master (
      output inicio, ulaOP, RS, RT,
      input  saidaULA, saidaHI, saidaLO, ocupado, pronto, divZero, opInvalido
   );

   modport slave (
      input  inicio, ulaOP, RS, RT,
      output saidaULA, saidaHI, saidaLO, ocupado, pronto, divZero, opInvalido
   );
endinterface

// File: rtl/ula_multiciclo.sv
// Multicycle unsigned ALU: single-cycle logic/arithmetic ops plus iterative
// shift-add multiply and restoring divide that update the HI/LO registers.
module ula_multiciclo #(
   parameter int LARGURA = 32
) (
   input logic             clock,
   input logic             reset,
   ula_multiciclo_if.slave bus
);
   localparam int            CW     = $clog2(LARGURA + 1);
   localparam logic [CW-1:0] ULTIMA = CW'(LARGURA - 1);

   localparam logic [4:0] OP_ADD   = 5'b00000;
   localparam logic [4:0] OP_SUB   = 5'b00001;
   localparam logic [4:0] OP_MUL   = 5'b00010;
   localparam logic [4:0] OP_DIV   = 5'b00011;
   localparam logic [4:0] OP_REM   = 5'b00100;
   localparam logic [4:0] OP_OR    = 5'b00101;
   localparam logic [4:0] OP_AND   = 5'b00110;
   localparam logic [4:0] OP_NOT   = 5'b00111;
   localparam logic [4:0] OP_XOR   = 5'b01000;
   localparam logic [4:0] OP_NOR   = 5'b01001;
   localparam logic [4:0] OP_NAND  = 5'b01010;
   localparam logic [4:0] OP_XNOR  = 5'b01011;
   localparam logic [4:0] OP_MAIOR = 5'b01110;

   typedef enum logic [1:0] {OCIOSO = 2'd0, MULT = 2'd1, DIV = 2'd2} estado_t;

   estado_t              estado_q, estado_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*LARGURA-1:0] acc_q, acc_d;
   logic [LARGURA-1:0]   divisor_q, divisor_d;
   logic                 eh_rem_q, eh_rem_d;
   logic [LARGURA-1:0]   saida_q, saida_d;
   logic [LARGURA-1:0]   hi_q, hi_d;
   logic [LARGURA-1:0]   lo_q, lo_d;
   logic                 ocupado_q, ocupado_d;
   logic                 pronto_q, pronto_d;
   logic                 divzero_q, divzero_d;
   logic                 opinv_q, opinv_d;

   logic                 aceita_s;
   logic                 eh_divrem_s;
   logic                 rt_zero_s;
   logic [LARGURA-1:0]   alu_s;
   logic                 alu_valida_s;
   logic [LARGURA:0]     mul_soma_s;
   logic [2*LARGURA-1:0] mul_prox_s;
   logic [LARGURA:0]     div_desl_s;
   logic [LARGURA:0]     div_dif_s;
   logic [2*LARGURA-1:0] div_prox_s;

   assign aceita_s    = bus.inicio && (estado_q == OCIOSO);
   assign eh_divrem_s = (bus.ulaOP == OP_DIV) || (bus.ulaOP == OP_REM);
   assign rt_zero_s   = (bus.RT == {LARGURA{1'b0}});

   // Single-cycle ALU result and opcode validity.
   always_comb begin
      alu_s        = {LARGURA{1'b0}};
      alu_valida_s = 1'b1;
      case (bus.ulaOP)
         OP_ADD:   alu_s = bus.RS + bus.RT;
         OP_SUB:   alu_s = bus.RS - bus.RT;
         OP_OR:    alu_s = bus.RS | bus.RT;
         OP_AND:   alu_s = bus.RS & bus.RT;
         OP_NOT:   alu_s = ~bus.RS;
         OP_XOR:   alu_s = bus.RS ^ bus.RT;
         OP_NOR:   alu_s = ~(bus.RS | bus.RT);
         OP_NAND:  alu_s = ~(bus.RS & bus.RT);
         OP_XNOR:  alu_s = ~(bus.RS ^ bus.RT);
         OP_MAIOR: alu_s = (bus.RS > bus.RT) ? {{(LARGURA-1){1'b0}}, 1'b1} : {LARGURA{1'b0}};
         OP_MUL, OP_DIV, OP_REM: alu_s = {LARGURA{1'b0}};
         default:  alu_valida_s = 1'b0;
      endcase
   end

   // One iteration step of each algorithm; acc holds {HI-part, LO-part}.
   // Multiply: LO-part is the shrinking multiplier, HI-part the partial sum.
   // Divide: LO-part shifts dividend bits out and quotient bits in, HI-part is the remainder.
   always_comb begin
      mul_soma_s = {1'b0, acc_q[2*LARGURA-1:LARGURA]}
                 + (acc_q[0] ? {1'b0, divisor_q} : {(LARGURA+1){1'b0}});
      mul_prox_s = {mul_soma_s, acc_q[LARGURA-1:1]};
      div_desl_s = {acc_q[2*LARGURA-1:LARGURA], acc_q[LARGURA-1]};
      div_dif_s  = div_desl_s - {1'b0, divisor_q};
      div_prox_s = {(div_dif_s[LARGURA] ? div_desl_s[LARGURA-1:0] : div_dif_s[LARGURA-1:0]),
                    acc_q[LARGURA-2:0], ~div_dif_s[LARGURA]};
   end

   // FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q <= OCIOSO;
      end else begin
         estado_q <= estado_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         OCIOSO: begin
            if (aceita_s && (bus.ulaOP == OP_MUL)) begin
               estado_d = MULT;
            end else if (aceita_s && eh_divrem_s && !rt_zero_s) begin
               estado_d = DIV;
            end else begin
               estado_d = OCIOSO;
            end
         end
         MULT, DIV: begin
            if (cnt_q == ULTIMA) begin
               estado_d = OCIOSO;
            end else begin
               estado_d = estado_q;
            end
         end
         default: estado_d = OCIOSO;
      endcase
   end

   // FSM output/datapath next values.
   always_comb begin
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      divisor_d = divisor_q;
      eh_rem_d  = eh_rem_q;
      saida_d   = saida_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pronto_d  = 1'b0;
      divzero_d = divzero_q;
      opinv_d   = opinv_q;
      ocupado_d = (estado_d != OCIOSO);
      case (estado_q)
         OCIOSO: begin
            if (aceita_s) begin
               cnt_d     = {CW{1'b0}};
               acc_d     = {{LARGURA{1'b0}}, bus.RS};
               divisor_d = bus.RT;
               eh_rem_d  = (bus.ulaOP == OP_REM);
               if (bus.ulaOP == OP_MUL) begin
                  pronto_d = 1'b0;
               end else if (eh_divrem_s && rt_zero_s) begin
                  // Division by zero completes at once: quotient all ones, remainder RS.
                  lo_d      = {LARGURA{1'b1}};
                  hi_d      = bus.RS;
                  saida_d   = (bus.ulaOP == OP_REM) ? bus.RS : {LARGURA{1'b1}};
                  pronto_d  = 1'b1;
                  divzero_d = 1'b1;
                  opinv_d   = 1'b0;
               end else if (eh_divrem_s) begin
                  pronto_d = 1'b0;
               end else begin
                  saida_d   = alu_s;
                  pronto_d  = 1'b1;
                  divzero_d = 1'b0;
                  opinv_d   = !alu_valida_s;
               end
            end else begin
               pronto_d = 1'b0;
            end
         end
         MULT: begin
            acc_d = mul_prox_s;
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_q == ULTIMA) begin
               hi_d      = mul_prox_s[2*LARGURA-1:LARGURA];
               lo_d      = mul_prox_s[LARGURA-1:0];
               saida_d   = mul_prox_s[LARGURA-1:0];
               pronto_d  = 1'b1;
               divzero_d = 1'b0;
               opinv_d   = 1'b0;
            end else begin
               pronto_d = 1'b0;
            end
         end
         DIV: begin
            acc_d = div_prox_s;
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_q == ULTIMA) begin
               hi_d      = div_prox_s[2*LARGURA-1:LARGURA];
               lo_d      = div_prox_s[LARGURA-1:0];
               saida_d   = eh_rem_q ? div_prox_s[2*LARGURA-1:LARGURA] : div_prox_s[LARGURA-1:0];
               pronto_d  = 1'b1;
               divzero_d = 1'b0;
               opinv_d   = 1'b0;
            end else begin
               pronto_d = 1'b0;
            end
         end
         default: begin
            cnt_d = {CW{1'b0}};
         end
      endcase
   end

   // Datapath and output registers; reset discards any partial result.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q     <= {CW{1'b0}};
         acc_q     <= {(2*LARGURA){1'b0}};
         divisor_q <= {LARGURA{1'b0}};
         eh_rem_q  <= 1'b0;
         saida_q   <= {LARGURA{1'b0}};
         hi_q      <= {LARGURA{1'b0}};
         lo_q      <= {LARGURA{1'b0}};
         ocupado_q <= 1'b0;
         pronto_q  <= 1'b0;
         divzero_q <= 1'b0;
         opinv_q   <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         divisor_q <= divisor_d;
         eh_rem_q  <= eh_rem_d;
         saida_q   <= saida_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         ocupado_q <= ocupado_d;
         pronto_q  <= pronto_d;
         divzero_q <= divzero_d;
         opinv_q   <= opinv_d;
      end
   end

   assign bus.saidaULA   = saida_q;
   assign bus.saidaHI    = hi_q;
   assign bus.saidaLO    = lo_q;
   assign bus.ocupado    = ocupado_q;
   assign bus.pronto     = pronto_q;
   assign bus.divZero    = divzero_q;
   assign bus.opInvalido = opinv_q;
endmodule
